// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 CALC cycles (done after edge k+32), div-by-zero/overflow finish after edge k.
// No backpressure: start is sampled only in IDLE and ignored while busy; done/wr_en are single-cycle pulses.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wr_en
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              neg_res;
  logic              neg_rem;

  logic              is_div, a_sgn, b_sgn, a_neg_in, b_neg_in, fast;
  logic [XLEN-1:0]   a_mag_in, b_mag_in, fast_res;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_sgn    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg_in = a_sgn & op_a[XLEN-1];
    b_neg_in = b_sgn & op_b[XLEN-1];
    a_mag_in = a_neg_in ? -op_a : op_a;
    b_mag_in = b_neg_in ? -op_b : op_b;
    fast     = 1'b0;
    fast_res = '0;
    if (is_div && op_b == '0) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? op_a : '1;
    end else if (is_div && !funct3[0] && op_a == INT_MIN && op_b == '1) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? '0 : INT_MIN;
    end
  end

  // Multiply keeps the multiplier in acc's low half; divide keeps {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, quo_f, rem_f, final_res;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod_f;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_ge   = div_sh[XLEN] | (div_sh[XLEN-1:0] >= b_mag);
    div_diff = div_sh[XLEN-1:0] - b_mag;
    div_nxt  = {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    acc_nxt  = op[2] ? div_nxt : mul_nxt;
    prod_f   = neg_res ? -acc_nxt : acc_nxt;
    quo_f    = neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_f    = neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    case (op)
      3'b000:         final_res = prod_f[XLEN-1:0];
      3'b100, 3'b101: final_res = quo_f;
      3'b110, 3'b111: final_res = rem_f;
      default:        final_res = prod_f[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op      <= '0;
      rd_out  <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op      <= funct3;
          rd_out  <= rd_in;
          a_mag   <= a_mag_in;
          b_mag   <= b_mag_in;
          acc     <= {{XLEN{1'b0}}, (is_div ? a_mag_in : b_mag_in)};
          cnt     <= '0;
          neg_res <= a_neg_in ^ b_neg_in;
          neg_rem <= a_neg_in;
          if (fast) result <= fast_res;
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) result <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign wr_en = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, sign rules, fast paths, busy/reset behaviour.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wr_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wr_en(wr_en)
  );

  // Issues one op and reports on which negedge after the accept edge done appeared (-1 = timeout).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic we, output logic [4:0] rdo);
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; res = 'x; we = 1'bx; rdo = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; res = result; we = wr_en; rdo = rd_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0 || wr_en !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done_wr: got done=%b wr_en=%b expected 0/0", done, wr_en);
    end
    tests_run++;
    if (result !== 32'h0 || rd_out !== 5'd0) begin
      tests_failed++; $display("FAIL reset_result_rd: got %h/%0d expected 0/0", result, rd_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int busy_err = 0;
    int early_done = 0;
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_err++;
      if (i < 33 && done !== 1'b0) early_done++;
    end
    tests_run++;
    if (busy_err != 0 || early_done != 0) begin
      tests_failed++; $display("FAIL mul_timeline: got busy_err=%0d early_done=%0d expected 0/0", busy_err, early_done);
    end
    tests_run++;
    if (done !== 1'b1 || wr_en !== 1'b1) begin
      tests_failed++; $display("FAIL mul_done: got done=%b wr_en=%b expected 1/1", done, wr_en);
    end
    tests_run++;
    if (result !== 32'hFFFF_FFEB || rd_out !== 5'd5) begin
      tests_failed++; $display("FAIL mul_result: got %h rd=%0d expected ffffffeb rd=5", result, rd_out);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("FAIL mul_return_idle: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_mul_high();
    logic [2:0]  f  [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] av [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    for (int i = 0; i < 3; i++) begin
      run_op(f[i], av[i], bv[i], 5'd10, lat, res, we, rdo);
      tests_run++;
      if (res !== ev[i] || lat != 33) begin
        tests_failed++; $display("FAIL mul_high_%0d: got %h lat=%0d expected %h lat=33", i, res, lat, ev[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] av [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bv [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ev [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], av[i], bv[i], 5'd11, lat, res, we, rdo);
      tests_run++;
      if (res !== ev[i] || lat != 33) begin
        tests_failed++; $display("FAIL div_%0d: got %h lat=%0d expected %h lat=33", i, res, lat, ev[i]);
      end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  f  [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] av [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], av[i], bv[i], 5'd12, lat, res, we, rdo);
      tests_run++;
      if (res !== ev[i] || lat != 1 || rdo !== 5'd12) begin
        tests_failed++;
        $display("FAIL fast_%0d: got %h lat=%0d rd=%0d expected %h lat=1 rd=12", i, res, lat, rdo, ev[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int extra_done = 0;
    int hold_err = 0;
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i < 33) begin
        if (done !== 1'b0) extra_done++;
        funct3 = 3'b000; op_a = $urandom; op_b = $urandom; rd_in = 5'd9;
      end
    end
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1 || result !== 32'd14 || rd_out !== 5'd3 || extra_done != 0) begin
      tests_failed++;
      $display("FAIL busy_ignore: got done=%b res=%h rd=%0d early=%0d expected 1/0000000e/3/0",
               done, result, rd_out, extra_done);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd14) hold_err++;
    end
    tests_run++;
    if (hold_err != 0) begin
      tests_failed++; $display("FAIL result_hold: got %0d bad cycles expected 0", hold_err);
    end
  endtask

  task automatic test_rd_zero();
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    run_op(3'b000, 32'd2, 32'd3, 5'd0, lat, res, we, rdo);
    tests_run++;
    if (lat != 33 || we !== 1'b0 || res !== 32'd6) begin
      tests_failed++; $display("FAIL rd_zero: got lat=%0d wr_en=%b res=%h expected 33/0/6", lat, we, res);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    int lat2 = -1;
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, lat, res, we, rdo);
    // Now in the DONE cycle: this start is ignored at the next edge and taken at the one after.
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd2; start = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (done) begin lat2 = i; break; end
    end
    start = 1'b0;
    tests_run++;
    if (lat2 != 34 || result !== 32'd14 || rd_out !== 5'd2) begin
      tests_failed++;
      $display("FAIL back_to_back: got gap=%0d res=%h rd=%0d expected 34/0000000e/2", lat2, result, rd_out);
    end
  endtask

  task automatic test_reset_mid();
    int stray_done = 0;
    int lat; logic [31:0] res; logic we; logic [4:0] rdo;
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (busy !== 1'b0 || result !== 32'd0 || done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid: got busy=%b res=%h done=%b expected 0/0/0", busy, result, done);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0) stray_done++;
    end
    tests_run++;
    if (stray_done != 0) begin
      tests_failed++; $display("FAIL reset_no_done: got %0d done cycles expected 0", stray_done);
    end
    run_op(3'b000, 32'd3, 32'd4, 5'd7, lat, res, we, rdo);
    tests_run++;
    if (res !== 32'd12 || lat != 33 || we !== 1'b1) begin
      tests_failed++; $display("FAIL after_reset_mul: got %h lat=%0d wr_en=%b expected 0000000c/33/1", res, lat, we);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_fast_path();
    test_busy_ignore();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
